// File: rtl/buffered_uart_rx.sv
// buffered_uart_rx: UART receiver with runtime bit divider and a
// first-word-fall-through receive FIFO with sticky error flags.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit per frame.
module buffered_uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          rx,
  input  logic [DIV_WIDTH-1:0]          divider,
  input  logic                          rd_en,
  input  logic                          clear_err,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          full,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          frame_error,
  output logic                          parity_error
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic                   armed_q, armed_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d, ferr_q, ferr_d, perr_q, perr_d;

  logic                   push_req, frame_set, par_set;
  logic                   do_push, do_pop, is_full, is_empty;
  logic [DIV_WIDTH-1:0]   div_clamped, target;
  logic                   tick;

  // Divider below 8 is forced up to 8 so START always has a meaningful half-bit wait.
  assign div_clamped = (divider < DIV_WIDTH'(8)) ? DIV_WIDTH'(8) : divider;
  assign target      = (state_q == START) ? ((div_q >> 1) - DIV_WIDTH'(1)) : (div_q - DIV_WIDTH'(1));
  assign tick        = (cnt_q == target);

  // Two-flop synchroniser for the asynchronous rx pad (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and frame datapath: bit timing, shifting and parity accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + DIV_WIDTH'(1);
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    // A new start is only accepted once rx has been seen high since the last frame.
    armed_d = rx_sync_q ? 1'b1 : ((state_q == IDLE) ? armed_q : 1'b0);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && armed_q && !rx_sync_q) begin
          state_d = START;
          div_d   = div_clamped;
        end
      end
      START: if (tick) begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_d = 1'b0;
`endif
        state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
        par_d   = par_q ^ rx_sync_q;
        if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_d   = '0;
        par_d   = par_q ^ rx_sync_q;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Frame outcome events from the stop-bit sample.
  always_comb begin
    push_req  = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    if (state_q == STOP && tick && enable) begin
      if (!rx_sync_q) frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (par_q) par_set = 1'b1;
`endif
      else push_req = 1'b1;
    end
  end

  // FIFO pointer/count bookkeeping and sticky flag updates.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(FIFO_DEPTH));
    do_pop   = rd_en && !is_empty;
    do_push  = push_req && (!is_full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    ovf_d  = (ovf_q  & ~clear_err) | (push_req && is_full && !do_pop);
    unf_d  = (unf_q  & ~clear_err) | (rd_en && is_empty);
    ferr_d = (ferr_q & ~clear_err) | frame_set;
    perr_d = (perr_q & ~clear_err) | par_set;
  end

  // Registers for frame datapath, FIFO control and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      div_q    <= DIV_WIDTH'(8);
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
    end
  end

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign data_out     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign data_ready   = (count_q != '0);
  assign fifo_count   = count_q;
  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign frame_error  = ferr_q;
  assign parity_error = perr_q;

endmodule

// File: tb/tb_buffered_uart_rx.sv
// Directed testbench for buffered_uart_rx (default parameters, divider 8).
module tb_buffered_uart_rx;

  logic        clk = 1'b0;
  logic        reset, enable, rx, rd_en, clear_err;
  logic [15:0] divider;
  logic [7:0]  data_out;
  logic        data_ready, full, overflow, underflow, frame_error, parity_error;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  buffered_uart_rx #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx), .divider(divider),
    .rd_en(rd_en), .clear_err(clear_err), .data_out(data_out),
    .data_ready(data_ready), .fifo_count(fifo_count), .full(full),
    .overflow(overflow), .underflow(underflow), .frame_error(frame_error),
    .parity_error(parity_error)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_out"}, 32'(data_out), 0);
    checkOutput({tag, "_data_ready"}, 32'(data_ready), 0);
    checkOutput({tag, "_count"}, 32'(fifo_count), 0);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 0);
    checkOutput({tag, "_underflow"}, 32'(underflow), 0);
    checkOutput({tag, "_frame_error"}, 32'(frame_error), 0);
    checkOutput({tag, "_parity_error"}, 32'(parity_error), 0);
  endtask

  // Drive one frame on rx with div cycles per bit. With pop_at_push, rd_en is
  // raised for exactly the edge on which the receiver pushes the word:
  // 2 sync cycles + 1 to enter START, div/2 to mid-start, then div per bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic bad_par, input int div, input logic pop_at_push);
    logic [11:0] bits;
    int nb;
    int pop_idx;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^data) ^ bad_par;
    bits[10] = stop_bit;
    nb = 11;
`else
    bits[9] = stop_bit;
    nb = 10;
    if (bad_par) $display("[TB] parity not compiled in, bad_par ignored");
`endif
    pop_idx = 3 + div / 2 + (nb - 1) * div - 1;
    for (int i = 0; i < nb * div; i++) begin
      @(negedge clk);
      rx    = bits[i / div];
      rd_en = pop_at_push && (i == pop_idx);
    end
    @(negedge clk);
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic popAndCheck(input string tag, input logic [7:0] exp);
    checkOutput(tag, 32'(data_out), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; rx = 1'b1; rd_en = 1'b0; clear_err = 1'b0;
    divider = 16'd8;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte then drain.
    applyStimulus(8'hA5, 1'b1, 1'b0, 8, 1'b0);
    checkOutput("a5_ready", 32'(data_ready), 1);
    checkOutput("a5_data", 32'(data_out), 32'hA5);
    checkOutput("a5_count", 32'(fifo_count), 1);
    popAndCheck("a5_pop", 8'hA5);
    checkOutput("a5_ready_after", 32'(data_ready), 0);
    checkOutput("a5_data_after", 32'(data_out), 0);

    // Bad stop bit.
    applyStimulus(8'h3C, 1'b0, 1'b0, 8, 1'b0);
    checkOutput("ferr_set", 32'(frame_error), 1);
    checkOutput("ferr_count", 32'(fifo_count), 0);
    pulseClear();
    checkOutput("ferr_clear", 32'(frame_error), 0);

    // False start at divider 16, then a real frame at that rate.
    divider = 16'd16;
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checkAllZero("false_start");
    applyStimulus(8'hC3, 1'b1, 1'b0, 16, 1'b0);
    checkOutput("div16_count", 32'(fifo_count), 1);
    popAndCheck("div16_data", 8'hC3);

    // Divider below 8 behaves as 8.
    divider = 16'd3;
    applyStimulus(8'h96, 1'b1, 1'b0, 8, 1'b0);
    checkOutput("clamp_count", 32'(fifo_count), 1);
    popAndCheck("clamp_data", 8'h96);
    divider = 16'd8;

    // Seventeen bytes without reading: the last one overflows.
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 1'b0, 8, 1'b0);
    checkOutput("ovf_full", 32'(full), 1);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("ovf_count", 32'(fifo_count), 16);
    for (int i = 0; i < 16; i++) popAndCheck($sformatf("ovf_read%0d", i), 8'(i));
    checkOutput("drain_count", 32'(fifo_count), 0);
    checkOutput("unf_before", 32'(underflow), 0);
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    checkOutput("unf_set", 32'(underflow), 1);
    checkOutput("unf_data", 32'(data_out), 0);
    pulseClear();
    checkOutput("clr_ovf", 32'(overflow), 0);
    checkOutput("clr_unf", 32'(underflow), 0);

    // Full FIFO: pop on the same edge as a push keeps count and raises no overflow.
    for (int i = 0; i < 16; i++) applyStimulus(8'h60 + 8'(i), 1'b1, 1'b0, 8, 1'b0);
    checkOutput("pp_full", 32'(full), 1);
    applyStimulus(8'h55, 1'b1, 1'b0, 8, 1'b1);
    checkOutput("pp_count", 32'(fifo_count), 16);
    checkOutput("pp_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) popAndCheck($sformatf("pp_read%0d", i), 8'h60 + 8'(i));
    popAndCheck("pp_last", 8'h55);
    checkOutput("pp_empty", 32'(data_ready), 0);

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h01, 1'b1, 1'b1, 8, 1'b0);
    checkOutput("perr_set", 32'(parity_error), 1);
    checkOutput("perr_count", 32'(fifo_count), 0);
    pulseClear();
`else
    checkOutput("perr_tied", 32'(parity_error), 0);
`endif

    // Enable dropped mid-frame discards the partial word.
    @(negedge clk); rx = 1'b0;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1; enable = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("en_count", 32'(fifo_count), 0);
    checkOutput("en_ferr", 32'(frame_error), 0);

    // Mid-frame reset with state present: everything clears, next frame is good.
    applyStimulus(8'h11, 1'b1, 1'b0, 8, 1'b0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 8, 1'b0);
    checkOutput("pre_rst_count", 32'(fifo_count), 1);
    @(negedge clk); rx = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("mid_reset");
    repeat (4) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 1'b0, 8, 1'b0);
    checkOutput("post_rst_count", 32'(fifo_count), 1);
    popAndCheck("post_rst_data", 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
